// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Register-file defaults and the one-hot decode helper.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_PC_IDX   = 15;
    localparam int DEF_PC_STEP  = 4;

    // Decoder width is fixed so one function serves any NUM_REGS up to 64.
    localparam int c_oh_w     = 64;
    localparam int c_oh_idx_w = 6;

    typedef struct packed {
        logic                  valid;
        logic [c_oh_idx_w-1:0] index;
    } onehot_t;

    function automatic onehot_t onehot_check(input logic [c_oh_w-1:0] vec);
        onehot_t     res;
        int unsigned cnt;
        res = '0;
        cnt = 0;
        for (int i = 0; i < c_oh_w; i++) begin
            if (vec[i]) begin
                cnt       = cnt + 1;
                res.index = c_oh_idx_w'(i);
            end
        end
        res.valid = (cnt == 1);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_sb_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb_if
//  Brief    : Write, load-return, issue and read bundle of the register file.
//  Revision : 1.0  initial release
// ============================================================================
interface reg_file_sb_if #(
    parameter int DATA_W   = cpu_pkg::DEF_DATA_W,
    parameter int NUM_REGS = cpu_pkg::DEF_NUM_REGS,
    parameter int ADDR_W   = cpu_pkg::DEF_ADDR_W
);
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] ld_en;
    logic [DATA_W-1:0]   ld_data;
    logic                ld_issue;
    logic [ADDR_W-1:0]   ld_issue_addr;
    logic                pc_inc;
    logic [ADDR_W-1:0]   rd_addr_a;
    logic [DATA_W-1:0]   rd_data_a;
    logic                rd_busy_a;
    logic [ADDR_W-1:0]   rd_addr_b;
    logic [DATA_W-1:0]   rd_data_b;
    logic                rd_busy_b;
    logic [DATA_W-1:0]   pc_out;
    logic [NUM_REGS-1:0] busy_vec;
    logic                err_ld;

    modport master (
        output wr_en, wr_addr, wr_data, ld_en, ld_data, ld_issue, ld_issue_addr,
               pc_inc, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, pc_out, busy_vec, err_ld
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, ld_en, ld_data, ld_issue, ld_issue_addr,
               pc_inc, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, pc_out, busy_vec, err_ld
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_sb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Brief    : Pending-load tracking per register with read-port busy lookup.
//  Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NUM_REGS = cpu_pkg::DEF_NUM_REGS,
    parameter int ADDR_W   = cpu_pkg::DEF_ADDR_W
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                i_issue,
    input  wire logic [ADDR_W-1:0]   i_issue_addr,
    input  wire logic                i_clr,
    input  wire logic [ADDR_W-1:0]   i_clr_idx,
    input  wire logic [ADDR_W-1:0]   i_rd_addr_a,
    input  wire logic                i_rd_ok_a,
    input  wire logic [ADDR_W-1:0]   i_rd_addr_b,
    input  wire logic                i_rd_ok_b,
    output logic      [NUM_REGS-1:0] o_busy_vec,
    output logic                     o_rd_busy_a,
    output logic                     o_rd_busy_b
);
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;

    // Issue wins over a same-cycle return: the newer load is still pending.
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_clr && (i_clr_idx == ADDR_W'(i)))
                w_busy_next[i] = 1'b0;
            if (i_issue && (i_issue_addr == ADDR_W'(i)))
                w_busy_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else
            r_busy <= w_busy_next;
    end

    assign o_busy_vec  = r_busy;
    assign o_rd_busy_a = i_rd_ok_a && r_busy[i_rd_addr_a] && !(i_clr && (i_clr_idx == i_rd_addr_a));
    assign o_rd_busy_b = i_rd_ok_b && r_busy[i_rd_addr_b] && !(i_clr && (i_clr_idx == i_rd_addr_b));

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb
//  Brief    : Clocked register file with bypassed reads, load scoreboard, PC.
//  Revision : 1.0  initial release
// ============================================================================
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PC_IDX   = DEF_PC_IDX,
    parameter int PC_STEP  = DEF_PC_STEP
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    reg_file_sb_if.slave bus
);
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_next [NUM_REGS];
    logic              r_err_ld;

    onehot_t           w_oh;
    logic              w_ld_ok;
    logic [ADDR_W-1:0] w_ld_idx;
    logic              w_unused_idx;
    logic              w_wr_ok;
    logic              w_issue_ok;
    logic              w_rd_ok_a;
    logic              w_rd_ok_b;
    logic              w_wr_go;

    assign w_oh         = onehot_check(c_oh_w'(bus.ld_en));
    assign w_ld_ok      = w_oh.valid;
    assign w_ld_idx     = w_oh.index[ADDR_W-1:0];
    assign w_unused_idx = ^w_oh.index;

    // With a fully populated index space every address is legal.
    if (NUM_REGS == (1 << ADDR_W)) begin : g_full_map
        assign w_wr_ok    = 1'b1;
        assign w_issue_ok = 1'b1;
        assign w_rd_ok_a  = 1'b1;
        assign w_rd_ok_b  = 1'b1;
    end else begin : g_part_map
        assign w_wr_ok    = (32'(bus.wr_addr)       < NUM_REGS);
        assign w_issue_ok = (32'(bus.ld_issue_addr) < NUM_REGS);
        assign w_rd_ok_a  = (32'(bus.rd_addr_a)     < NUM_REGS);
        assign w_rd_ok_b  = (32'(bus.rd_addr_b)     < NUM_REGS);
    end

    assign w_wr_go = bus.wr_en && w_wr_ok;

    // Later assignments win: load return > ALU write-back > pc_inc.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_next[i] = r_regs[i];
            if ((i == PC_IDX) && bus.pc_inc)
                w_next[i] = r_regs[i] + DATA_W'(PC_STEP);
            if (w_wr_go && (bus.wr_addr == ADDR_W'(i)))
                w_next[i] = bus.wr_data;
            if (w_ld_ok && bus.ld_en[i])
                w_next[i] = bus.ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
            r_err_ld <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= w_next[i];
            if ((|bus.ld_en) && !w_ld_ok)
                r_err_ld <= 1'b1;
        end
    end

    // The pc_inc result is deliberately not forwarded to the read ports.
    assign bus.rd_data_a = !w_rd_ok_a                                 ? '0          :
                           (w_ld_ok && (w_ld_idx == bus.rd_addr_a))   ? bus.ld_data :
                           (w_wr_go && (bus.wr_addr == bus.rd_addr_a)) ? bus.wr_data :
                                                                        r_regs[bus.rd_addr_a];

    assign bus.rd_data_b = !w_rd_ok_b                                 ? '0          :
                           (w_ld_ok && (w_ld_idx == bus.rd_addr_b))   ? bus.ld_data :
                           (w_wr_go && (bus.wr_addr == bus.rd_addr_b)) ? bus.wr_data :
                                                                        r_regs[bus.rd_addr_b];

    assign bus.pc_out = r_regs[PC_IDX];
    assign bus.err_ld = r_err_ld;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_issue      (bus.ld_issue && w_issue_ok),
        .i_issue_addr (bus.ld_issue_addr),
        .i_clr        (w_ld_ok),
        .i_clr_idx    (w_ld_idx),
        .i_rd_addr_a  (bus.rd_addr_a),
        .i_rd_ok_a    (w_rd_ok_a),
        .i_rd_addr_b  (bus.rd_addr_b),
        .i_rd_ok_b    (w_rd_ok_b),
        .o_busy_vec   (bus.busy_vec),
        .o_rd_busy_a  (bus.rd_busy_a),
        .o_rd_busy_b  (bus.rd_busy_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_sb
//  Brief    : Directed self-checking bench for reg_file_sb.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_sb;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    reg_file_sb_if #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4)) bus ();

    reg_file_sb #(
        .DATA_W   (32),
        .NUM_REGS (16),
        .ADDR_W   (4),
        .PC_IDX   (15),
        .PC_STEP  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.wr_en         = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.ld_en         = '0;
        bus.ld_data       = '0;
        bus.ld_issue      = 1'b0;
        bus.ld_issue_addr = '0;
        bus.pc_inc        = 1'b0;
    endtask

    // Clock one edge, then drop the write-side strobes so stored state is visible.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle();
        bus.rd_addr_a = 4'd0;
        bus.rd_addr_b = 4'd0;

        // Reset state
        #3;
        check_eq("rst_rd_a",   bus.rd_data_a, 32'h0);
        check_eq("rst_rd_b",   bus.rd_data_b, 32'h0);
        check_eq("rst_pc",     bus.pc_out,    32'h0);
        check_eq("rst_busy",   32'(bus.busy_vec), 32'h0);
        check_eq("rst_err",    32'(bus.err_ld),   32'h0);
        check_eq("rst_busy_a", 32'(bus.rd_busy_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU write with same-cycle bypass
        bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 32'hDEADBEEF;
        bus.rd_addr_a = 4'd3;
        #1 check_eq("wr_bypass", bus.rd_data_a, 32'hDEADBEEF);
        tick();
        check_eq("wr_stored", bus.rd_data_a, 32'hDEADBEEF);

        // Issue then return on r5
        bus.ld_issue = 1'b1; bus.ld_issue_addr = 4'd5; bus.rd_addr_b = 4'd5;
        tick();
        check_eq("iss_busy_vec", 32'(bus.busy_vec), 32'h0000_0020);
        check_eq("iss_busy_b",   32'(bus.rd_busy_b), 32'h1);
        bus.ld_en = 16'h0020; bus.ld_data = 32'h12345678;
        #1;
        check_eq("ret_bypass",   bus.rd_data_b, 32'h12345678);
        check_eq("ret_busy_b",   32'(bus.rd_busy_b), 32'h0);
        check_eq("ret_vec_pre",  32'(bus.busy_vec), 32'h0000_0020);
        tick();
        check_eq("ret_vec_post", 32'(bus.busy_vec), 32'h0);
        check_eq("ret_stored",   bus.rd_data_b, 32'h12345678);

        // Load, ALU write and issue all on r2
        bus.ld_en = 16'h0004; bus.ld_data = 32'h11;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 32'h22;
        bus.ld_issue = 1'b1; bus.ld_issue_addr = 4'd2;
        bus.rd_addr_a = 4'd2;
        #1 check_eq("prio_bypass", bus.rd_data_a, 32'h11);
        tick();
        check_eq("prio_stored", bus.rd_data_a, 32'h11);
        check_eq("prio_vec",    32'(bus.busy_vec), 32'h0000_0004);
        check_eq("prio_busy_a", 32'(bus.rd_busy_a), 32'h1);

        // ALU write to a busy register keeps the busy bit
        bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 32'h22;
        #1 check_eq("alu_busy_byp", bus.rd_data_a, 32'h22);
        check_eq("alu_busy_a", 32'(bus.rd_busy_a), 32'h1);
        tick();
        check_eq("alu_busy_vec", 32'(bus.busy_vec), 32'h0000_0004);
        check_eq("alu_busy_dat", bus.rd_data_a, 32'h22);

        // PC wrap and write suppressing pc_inc
        bus.wr_en = 1'b1; bus.wr_addr = 4'd15; bus.wr_data = 32'hFFFFFFFC;
        tick();
        check_eq("pc_load", bus.pc_out, 32'hFFFFFFFC);
        bus.pc_inc = 1'b1; bus.rd_addr_a = 4'd15;
        #1;
        check_eq("pc_no_byp", bus.rd_data_a, 32'hFFFFFFFC);
        check_eq("pc_pre",    bus.pc_out,    32'hFFFFFFFC);
        tick();
        check_eq("pc_wrap", bus.pc_out, 32'h0);
        bus.pc_inc = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd15; bus.wr_data = 32'h100;
        #1;
        check_eq("pc_wr_byp", bus.rd_data_a, 32'h100);
        check_eq("pc_out_stored", bus.pc_out, 32'h0);
        tick();
        check_eq("pc_wr_wins", bus.pc_out, 32'h100);
        bus.pc_inc = 1'b1;
        tick();
        check_eq("pc_step", bus.pc_out, 32'h104);
        bus.pc_inc = 1'b1; bus.ld_en = 16'h8000; bus.ld_data = 32'h200;
        tick();
        check_eq("pc_ld_wins", bus.pc_out, 32'h200);

        // Multi-hot load return
        bus.rd_addr_a = 4'd0; bus.rd_addr_b = 4'd3;
        bus.ld_en = 16'h0009; bus.ld_data = 32'hFF;
        #1;
        check_eq("mh_no_byp_a", bus.rd_data_a, 32'h0);
        check_eq("mh_no_byp_b", bus.rd_data_b, 32'hDEADBEEF);
        tick();
        check_eq("mh_r0",   bus.rd_data_a, 32'h0);
        check_eq("mh_r3",   bus.rd_data_b, 32'hDEADBEEF);
        check_eq("mh_err",  32'(bus.err_ld), 32'h1);
        bus.ld_en = 16'h0006; bus.ld_data = 32'hEE; bus.rd_addr_a = 4'd2;
        tick();
        check_eq("mh_no_clr", 32'(bus.busy_vec), 32'h0000_0004);
        check_eq("mh_r2",     bus.rd_data_a, 32'h22);
        bus.ld_en = 16'h0004; bus.ld_data = 32'h33;
        tick();
        check_eq("err_sticky", 32'(bus.err_ld), 32'h1);
        check_eq("ok_clr",     32'(bus.busy_vec), 32'h0);
        check_eq("ok_r2",      bus.rd_data_a, 32'h33);

        // Issue to an already busy register
        bus.ld_issue = 1'b1; bus.ld_issue_addr = 4'd7;
        tick();
        bus.ld_issue = 1'b1; bus.ld_issue_addr = 4'd7;
        tick();
        check_eq("reiss_vec", 32'(bus.busy_vec), 32'h0000_0080);
        check_eq("reiss_err", 32'(bus.err_ld), 32'h1);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_pc",   bus.pc_out,    32'h0);
        check_eq("arst_rd_a", bus.rd_data_a, 32'h0);
        check_eq("arst_rd_b", bus.rd_data_b, 32'h0);
        check_eq("arst_busy", 32'(bus.busy_vec), 32'h0);
        check_eq("arst_err",  32'(bus.err_ld), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stale return after reset writes data, busy stays clear
        bus.ld_en = 16'h0080; bus.ld_data = 32'hAB; bus.rd_addr_a = 4'd7;
        #1 check_eq("stale_busy_a", 32'(bus.rd_busy_a), 32'h0);
        tick();
        check_eq("stale_data", bus.rd_data_a, 32'hAB);
        check_eq("stale_vec",  32'(bus.busy_vec), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised CPU register file that succeeds the one-hot-load, latch-style register bank. It is fully clocked with reset. It provides:
- one ALU write-back port and one memory-load return port, the load port keeping the one-hot enable style;
- two combinational read ports with same-cycle write bypass;
- a pending-load scoreboard so the issue stage can stall on registers whose load has not yet returned;
- auto-increment of the PC register.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 16, number of architectural registers (>=2)
ADDR_W, 4, register index width; must equal clog2(NUM_REGS)
PC_IDX, 15, index of the program-counter register
PC_STEP, 4, value added to the PC register on pc_inc

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
wr_en  in  1  ALU write-back strobe
wr_addr  in  ADDR_W  ALU write-back target
wr_data  in  DATA_W  ALU write-back data
ld_en  in  NUM_REGS  one-hot load-return enable (bit i targets register i)
ld_data  in  DATA_W  load-return data
ld_issue  in  1  load issued; marks target pending
ld_issue_addr  in  ADDR_W  target of issued load
pc_inc  in  1  advance PC register by PC_STEP
rd_addr_a  in  ADDR_W  read port A index
rd_data_a  out  DATA_W  read port A data
rd_busy_a  out  1  port A register has a load pending
rd_addr_b  in  ADDR_W  read port B index
rd_data_b  out  DATA_W  read port B data
rd_busy_b  out  1  port B register has a load pending
pc_out  out  DATA_W  current PC register value
busy_vec  out  NUM_REGS  scoreboard, bit i = register i pending
err_ld  out  1  sticky: ld_en seen with more than one bit set

Behaviour:
Reset:
- rst_n low sets all registers, busy_vec and err_ld to 0 immediately, independent of clk.
- Outputs follow from this: rd_data_a/b = 0, pc_out = 0, rd_busy_a/b = 0.

Writes:
- All register updates occur on the rising edge of clk.
- Addresses >= NUM_REGS are ignored on every port: no write, no scoreboard change, read data 0, read busy 0.

Load port:
- ld_en with exactly one bit set writes ld_data to that register.
- ld_en = 0: no load write.
- ld_en with two or more bits set: no load write, no scoreboard clear, err_ld set. err_ld stays set until reset.

Write priority, same register in the same cycle: load return > ALU write-back > pc_inc.
- A write to PC_IDX from either port suppresses pc_inc that cycle.
- Otherwise pc_inc sets PC <= PC + PC_STEP, modulo 2^DATA_W (wraps 0xFFFFFFFC -> 0x00000000 at defaults).

Reads (combinational, zero latency):
- rd_data_x = data being written to rd_addr_x this cycle (write-through bypass, using the priority above), else the stored value.
- The pc_inc result is not bypassed.
- pc_out shows the stored PC only.

Scoreboard:
- A valid ld_issue sets busy[ld_issue_addr] at the edge.
- A valid one-hot ld_en clears the targeted busy bit at the edge.
- Issue and return to the same register in the same cycle: the bit ends up set (the new load is pending).
- Issue to an already-busy register: the bit stays set; no error.
- ALU write to a busy register: the data is written, the busy bit is unchanged.
- A load return to a non-busy register: the data is written, the bit stays 0.
- rd_busy_x = busy[rd_addr_x] AND NOT (valid load return to rd_addr_x this cycle). This is consistent with the bypass.

Reset mid-operation: all pending loads are forgotten. Returns arriving after reset write their data but leave busy at 0.

Decomposition:
Shared package cpu_pkg holds:
- DATA_W, NUM_REGS, ADDR_W, PC_IDX, PC_STEP defaults;
- the PC_STEP constant;
- a function onehot_check(vec) returning {valid, index}.

One sub-module is natural: reg_scoreboard, which owns busy_vec, the set/clear priority and the rd_busy lookups. The data array, bypass muxes and PC logic stay in reg_file_sb.

Test Plan:
1. Reset then idle -> all reads 0, pc_out 0, busy_vec 0, err_ld 0. Assert rst_n low mid-cycle after writes -> all outputs return to 0 before the next edge.
2. wr_en=1, wr_addr=3, wr_data=0xDEADBEEF with rd_addr_a=3 in the same cycle -> rd_data_a=0xDEADBEEF combinationally, and stored after the edge.
3. ld_issue to r5 -> busy_vec=0x0020 and rd_busy_b=1 (rd_addr_b=5). Next, ld_en=0x0020, ld_data=0x12345678 -> rd_data_b=0x12345678 and rd_busy_b=0 in that cycle; busy_vec=0 after the edge.
4. Same cycle: ld_en=0x0004 (0x11), wr_en to r2 (0x22), ld_issue r2 -> r2=0x11 and busy[2]=1 after the edge.
5. PC=0xFFFFFFFC, pc_inc=1 -> pc_out=0. Then pc_inc=1 with wr_en to r15 (0x100) -> pc_out=0x100.
6. ld_en=0x0009, ld_data=0xFF -> r0 and r3 unchanged, err_ld=1 and held through later valid loads until rst_n low.
